apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_master_ctrl.sv | 118 +++++++++++
 tb/tb_apb_master_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB master: turns one cmd_valid/cmd_ready command into a SETUP/ACCESS transfer to one of three slaves.
// Latency: response 3 cycles after accept plus APB wait states; cmd_ready is low while a transfer is in flight.
module apb_master_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } state_t;

  // Counter value at the start of the last ACCESS cycle allowed before abort.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [2:0]  sel_dec;

  // Each slave owns a 64 MiB window starting at 0x8000_0000.
  always_comb begin
    sel_dec = 3'b000;
    case (cmd_addr[31:26])
      6'b100000: sel_dec = 3'b001;
      6'b100001: sel_dec = 3'b010;
      6'b100010: sel_dec = 3'b100;
      default:   sel_dec = 3'b000;
    endcase
  end

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      psel      <= 3'b000;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'd0;
      pwdata    <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            if (sel_dec != 3'b000) begin
              psel  <= sel_dec;
              state <= SETUP;
            end else begin
              state <= DECERR;
            end
          end
        end
        SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= 8'd0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over a timeout landing in the same cycle.
          if (pready) begin
            psel      <= 3'b000;
            penable   <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : 32'd0;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= wait_cnt + 8'd1;
            psel      <= 3'b000;
            penable   <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECERR: begin
          state     <= IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: fixed vectors, randomized commands against a transaction-level model,
// plus hand sequences for back-to-back commands and reset in the middle of a transfer.
module tb_apb_master_ctrl;

  localparam int TB_TIMEOUT = 16;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata = 32'd0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int          slave_waits = 0;
  logic        slave_err = 1'b0;
  logic [31:0] slave_rdata = 32'd0;
  int          acc_cnt = 0;

  int n_tests = 0;
  int n_fail = 0;

  apb_master_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  // Slave model: holds pready low for slave_waits ACCESS cycles, then raises it.
  always @(negedge hclk) begin
    if (penable) begin
      acc_cnt = acc_cnt + 1;
      pready  = (acc_cnt > slave_waits);
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom_range(0, 1));
    end
    pslverr = slave_err;
    prdata  = slave_rdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level expectation derived from the address map and timeout rule.
  function automatic void model(input logic wr, input logic [31:0] addr, input int waits,
                                input logic serr, input logic [31:0] rd,
                                output logic [2:0] e_psel, output int e_lat,
                                output logic e_err, output logic [31:0] e_rdata);
    if (addr >= 32'h8000_0000 && addr <= 32'h83FF_FFFF)      e_psel = 3'b001;
    else if (addr >= 32'h8400_0000 && addr <= 32'h87FF_FFFF) e_psel = 3'b010;
    else if (addr >= 32'h8800_0000 && addr <= 32'h8BFF_FFFF) e_psel = 3'b100;
    else                                                     e_psel = 3'b000;
    if (e_psel == 3'b000) begin
      e_lat = 2; e_err = 1'b1; e_rdata = 32'd0;
    end else if (waits >= TB_TIMEOUT) begin
      e_lat = 2 + TB_TIMEOUT; e_err = 1'b1; e_rdata = 32'd0;
    end else begin
      e_lat = 3 + waits; e_err = serr; e_rdata = (!wr && !serr) ? rd : 32'd0;
    end
  endfunction

  // Issues one command and watches the bus until the response (bounded).
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic serr, input logic [31:0] rd,
                         output int lat, output logic [2:0] psel_seen,
                         output logic r_err, output logic [31:0] r_rdata, output int bad);
    slave_waits = waits;
    slave_err   = serr;
    slave_rdata = rd;
    lat = -1; psel_seen = 3'b000; r_err = 1'bx; r_rdata = 32'hxxxx_xxxx; bad = 0;
    @(negedge hclk);
    if (cmd_ready !== 1'b1) bad++;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge hclk);
    #1 cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 300; k++) begin
      @(negedge hclk);
      if ($countones(psel) > 1) bad++;
      if (penable && psel == 3'b000) bad++;
      if (psel != 3'b000 && (paddr !== addr || pwrite !== wr || pwdata !== wdata)) bad++;
      psel_seen |= psel;
      if (rsp_valid) begin
        if (psel != 3'b000 || penable || cmd_ready !== 1'b1) bad++;
        lat = k; r_err = rsp_err; r_rdata = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic check_txn(input string tag, input logic [2:0] e_psel, input int e_lat,
                           input logic e_err, input logic [31:0] e_rdata,
                           input logic [2:0] psel_seen, input int lat,
                           input logic r_err, input logic [31:0] r_rdata, input int bad);
    chk({tag, "_psel"}, 32'(psel_seen), 32'(e_psel));
    chk({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(r_err), 32'(e_err));
    chk({tag, "_rdata"}, r_rdata, e_rdata);
    chk({tag, "_bus"}, 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          waits;
    logic        serr;
    logic [2:0]  e_psel;
    int          e_lat;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat, bad, cnt;
    logic [2:0]  ps, e_ps;
    logic        er, e_er;
    logic [31:0] rd, e_rd, a;
    int          e_lat, w;
    logic        wr, se;

    vecs[0] = '{1'b0, 32'h8000_0010, 32'h0,         32'h0000_00A5, 0,   1'b0, 3'b001, 3,  1'b0, 32'h0000_00A5};
    vecs[1] = '{1'b1, 32'h8400_0004, 32'hDEAD_BEEF, 32'h1111_1111, 3,   1'b0, 3'b010, 6,  1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h8800_0000, 32'h0,         32'h2222_2222, 255, 1'b0, 3'b100, 18, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h8800_0000, 32'h0,         32'h0000_1234, 15,  1'b0, 3'b100, 18, 1'b0, 32'h0000_1234};
    vecs[4] = '{1'b1, 32'h9000_0000, 32'h5A5A_5A5A, 32'h3333_3333, 0,   1'b0, 3'b000, 2,  1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h83FF_FFFC, 32'h0,         32'h0000_FFFF, 1,   1'b1, 3'b001, 4,  1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'h8BFF_FFFF, 32'h0,         32'h0000_0055, 2,   1'b0, 3'b100, 5,  1'b0, 32'h0000_0055};
    vecs[7] = '{1'b0, 32'h7FFF_FFFF, 32'h0,         32'h4444_4444, 0,   1'b0, 3'b000, 2,  1'b1, 32'h0};
    vecs[8] = '{1'b0, 32'h8C00_0000, 32'h0,         32'h5555_5555, 0,   1'b0, 3'b000, 2,  1'b1, 32'h0};
    vecs[9] = '{1'b0, 32'h8800_0000, 32'h0,         32'h6666_6666, 16,  1'b0, 3'b100, 18, 1'b1, 32'h0};

    // Reset, with a valid command presented the whole time.
    #2 hresetn = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0000; cmd_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge hclk);
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;
    hresetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].serr, vecs[i].rd,
              lat, ps, er, rd, bad);
      check_txn($sformatf("vec%0d", i), vecs[i].e_psel, vecs[i].e_lat, vecs[i].e_err,
                vecs[i].e_rdata, ps, lat, er, rd, bad);
    end

    // Back-to-back writes with cmd_valid held; the second sees pslverr.
    slave_waits = 0; slave_err = 1'b0; slave_rdata = 32'h7777_7777;
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0100; cmd_wdata = 32'h0000_0001;
    @(posedge hclk);
    #1 cmd_addr = 32'h8400_0200; cmd_wdata = 32'h0000_0002;
    cnt = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge hclk);
      if (rsp_valid) begin cnt = k; break; end
    end
    chk("b2b_first_lat", 32'(cnt), 32'd3);
    chk("b2b_first_err", 32'(rsp_err), 32'd0);
    chk("b2b_ready_in_rsp", 32'(cmd_ready), 32'd1);
    slave_err = 1'b1;
    @(posedge hclk);
    #1 cmd_valid = 1'b0;
    @(negedge hclk);
    chk("b2b_setup_psel", 32'(psel), 32'b010);
    chk("b2b_setup_penable", 32'(penable), 32'd0);
    chk("b2b_setup_paddr", paddr, 32'h8400_0200);
    cnt = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge hclk);
      if (rsp_valid) begin cnt = k; break; end
    end
    chk("b2b_second_lat", 32'(cnt), 32'd2);
    chk("b2b_second_err", 32'(rsp_err), 32'd1);
    chk("b2b_second_rdata", rsp_rdata, 32'd0);
    slave_err = 1'b0;

    // Reset pulsed during ACCESS.
    slave_waits = 1000;
    @(negedge hclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0040; cmd_wdata = 32'hCAFE_F00D;
    @(posedge hclk);
    #1 cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge hclk);
      if (penable) break;
    end
    chk("rstmid_in_access", 32'(penable), 32'd1);
    repeat (2) @(negedge hclk);
    #1 hresetn = 1'b0;
    #1;
    chk("rstmid_psel", 32'(psel), 32'd0);
    chk("rstmid_penable", 32'(penable), 32'd0);
    chk("rstmid_paddr", paddr, 32'd0);
    chk("rstmid_pwdata", pwdata, 32'd0);
    chk("rstmid_pwrite", 32'(pwrite), 32'd0);
    chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_addr = 32'h8400_0000;
    repeat (3) @(negedge hclk);
    chk("rstmid_no_accept", 32'(psel), 32'd0);
    cmd_valid = 1'b0;
    hresetn = 1'b1;
    slave_waits = 0;
    cnt = 0;
    repeat (6) begin
      @(negedge hclk);
      if (rsp_valid || psel != 3'b000) cnt++;
    end
    chk("rstmid_silent", 32'(cnt), 32'd0);
    run_txn(1'b0, 32'h8400_0008, 32'h0, 1, 1'b0, 32'h0BAD_F00D, lat, ps, er, rd, bad);
    check_txn("rstmid_next", 3'b010, 4, 1'b0, 32'h0BAD_F00D, ps, lat, er, rd, bad);

    // Randomized commands against the model.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'h8000_0000 | ($urandom & 32'h03FF_FFFF);
        1: a = 32'h8400_0000 | ($urandom & 32'h03FF_FFFF);
        2: a = 32'h8800_0000 | ($urandom & 32'h03FF_FFFF);
        3: a = $urandom & 32'h7FFF_FFFF;
        default: a = $urandom | 32'h8C00_0000;
      endcase
      wr = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 3) == 0);
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      e_rd = $urandom;
      model(wr, a, w, se, e_rd, e_ps, e_lat, e_er, rd);
      run_txn(wr, a, $urandom, w, se, e_rd, lat, ps, er, e_rd, bad);
      check_txn($sformatf("rnd%0d", i), e_ps, e_lat, e_er, rd, ps, lat, er, e_rd, bad);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
